// File: rtl/serial_mux_adder.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSD first, mux-built majority carries.
// Latency: done pulses N=WIDTH/DIGIT cycles after the accepting edge; start is ignored while busy.
module serial_mux_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_mux_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] dsum_ext;
    logic             dcarry;
    logic             msb_cin;
    logic             last;

    // Carry slice: propagate the incoming carry when a^b, otherwise a==b is the carry.
    always_comb begin
        logic c;
        c        = carry_q;
        dsum     = '0;
        msb_cin  = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = a_q[i] ^ b_q[i] ^ c;
            msb_cin = c;
            c       = (a_q[i] ^ b_q[i]) ? c : a_q[i];
        end
        dcarry   = c;
        dsum_ext = '0;
        dsum_ext[DIGIT-1:0] = dsum;
    end

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Operands shift down so the active digit always sits at bit 0.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (res_q >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
                carry_d = dcarry;
                if (last) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = dcarry;
                    ovf_d   = msb_cin ^ dcarry;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_mux_adder.sv
// Bench for serial_mux_adder: four instances (DIGIT 1,2,4,8) against an arithmetic model.
module tb_serial_mux_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [3:0]   start;
    logic [3:0]   busy_w, done_w, cout_w, ovf_w;
    logic [W-1:0] sum_w [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_mux_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .overflow(ovf_w[0]));
    serial_mux_adder #(.WIDTH(W), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .overflow(ovf_w[1]));
    serial_mux_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .overflow(ovf_w[2]));
    serial_mux_adder #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start[3]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_w[3]), .done(done_w[3]), .sum(sum_w[3]), .cout(cout_w[3]), .overflow(ovf_w[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Digit cycles for instance idx (DIGIT = 1 << idx).
    function automatic int nn(input int idx);
        return W >> idx;
    endfunction

    // Returns {overflow, cout, sum[7:0]}.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mc, input logic ms);
        logic [7:0] bb;
        logic [8:0] full;
        logic       ov;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {8'd0, mc ^ ms};
        ov   = (ma[7] == bb[7]) && (full[7] != ma[7]);
        return {ov, full[8], full[7:0]};
    endfunction

    // Counts cycles until done; optionally scrambles inputs and pulses start while running.
    task automatic wait_done(input int idx, input bit noise, input bit hold_start,
                             output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!done_w[idx] && lat < 40) begin
            if (busy_w[idx]) nbusy++;
            if (noise) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
                if (!hold_start) start[idx] = 1'($urandom);
            end
            tick;
            lat++;
        end
    endtask

    task automatic run_op(input int idx, input logic [7:0] ta, input logic [7:0] tb2,
                          input logic tc, input logic ts, input bit noise);
        logic [9:0] e;
        int lat, nbusy;
        e = model(ta, tb2, tc, ts);
        a = ta; b = tb2; cin = tc; sub = ts;
        start[idx] = 1'b1;
        tick;
        start[idx] = 1'b0;
        wait_done(idx, noise, 1'b0, lat, nbusy);
        start[idx] = 1'b0;
        chk("latency", lat, nn(idx));
        chk("busy_cycles", nbusy, nn(idx));
        chk("busy_at_done", {31'd0, busy_w[idx]}, 0);
        chk("sum", {24'd0, sum_w[idx]}, {24'd0, e[7:0]});
        chk("cout", {31'd0, cout_w[idx]}, {31'd0, e[8]});
        chk("overflow", {31'd0, ovf_w[idx]}, {31'd0, e[9]});
        tick;
        chk("done_one_cycle", {31'd0, done_w[idx]}, 0);
        chk("sum_hold", {24'd0, sum_w[idx]}, {24'd0, e[7:0]});
    endtask

    // start held high: each result must match the operands present at its own accept edge.
    task automatic back_to_back(input int idx, input int count);
        logic [7:0] oa, ob;
        logic       oc, os;
        logic [9:0] e;
        int lat, nbusy;
        oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom); os = 1'($urandom);
        a = oa; b = ob; cin = oc; sub = os;
        start[idx] = 1'b1;
        for (int j = 0; j < count; j++) begin
            e = model(oa, ob, oc, os);
            tick;
            wait_done(idx, 1'b1, 1'b1, lat, nbusy);
            chk("b2b_period", lat, nn(idx));
            chk("b2b_sum", {24'd0, sum_w[idx]}, {24'd0, e[7:0]});
            chk("b2b_cout", {31'd0, cout_w[idx]}, {31'd0, e[8]});
            oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom); os = 1'($urandom);
            a = oa; b = ob; cin = oc; sub = os;
            if (j == count - 1) start[idx] = 1'b0;
        end
        tick;
        chk("b2b_end_done", {31'd0, done_w[idx]}, 0);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick;
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("rst_busy", {31'd0, busy_w[i]}, 0);
            chk("rst_done", {31'd0, done_w[i]}, 0);
            chk("rst_sum", {24'd0, sum_w[i]}, 0);
            chk("rst_cout", {31'd0, cout_w[i]}, 0);
            chk("rst_ovf", {31'd0, ovf_w[i]}, 0);
        end
        rst = 1'b0;
        tick;

        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op(1, 8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
        run_op(2, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) back_to_back(i, 4);

        // Abort in the third RUN cycle: outputs clear and no done follows.
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        a = 8'h33; b = 8'h11; cin = 1'b0; sub = 1'b0;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy_w[0]}, 0);
        chk("abort_done", {31'd0, done_w[0]}, 0);
        chk("abort_sum", {24'd0, sum_w[0]}, 0);
        chk("abort_cout", {31'd0, cout_w[0]}, 0);
        chk("abort_ovf", {31'd0, ovf_w[0]}, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_w[0]) ndone++;
            tick;
        end
        chk("abort_no_done", ndone, 0);
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 25; k++) begin
                run_op(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
